// File: rtl/range_browser_if.sv
// Key/switch inputs and range-engine handshake bundled for range_browser.
// The testbench drives the master side; range_browser takes the slave side.
interface range_browser_if #(
  parameter int N_WIDTH = 12
);
  logic               go_key_n;
  logic               inc_key_n;
  logic               dec_key_n;
  logic               home_key_n;
  logic [N_WIDTH-1:0] sw;
  logic               range_done;
  logic               range_go;
  logic [31:0]        range_start;
  logic [N_WIDTH-1:0] disp_n;
  logic               browsing;

  modport master (
    output go_key_n, inc_key_n, dec_key_n, home_key_n, sw, range_done,
    input  range_go, range_start, disp_n, browsing
  );

  modport slave (
    input  go_key_n, inc_key_n, dec_key_n, home_key_n, sw, range_done,
    output range_go, range_start, disp_n, browsing
  );
endinterface

// File: rtl/range_browser.sv
// Launches the range engine with a base n from the switches, then browses result offsets with
// auto-repeating keys. Define RANGE_BROWSER_WRAP_EN to wrap the offset instead of saturating.
module range_browser #(
  parameter int N_WIDTH       = 12,
  parameter int DEPTH         = 256,
  parameter int ADDR_BITS     = 8,
  parameter int HOLD_CYCLES   = 3145728,
  parameter int REPEAT_CYCLES = 3145728,
  parameter int TMR_BITS      = 22
) (
  input  logic         clk,
  input  logic         reset_n,
  range_browser_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_BROWSE    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    K_NONE = 2'd0,
    K_HOME = 2'd1,
    K_INC  = 2'd2,
    K_DEC  = 2'd3
  } key_t;

  localparam logic [ADDR_BITS-1:0] OFF_MAX   = ADDR_BITS'(DEPTH - 1);
  localparam logic [TMR_BITS-1:0]  HOLD_LAST = TMR_BITS'(HOLD_CYCLES - 1);
  localparam logic [TMR_BITS-1:0]  REP_LAST  = TMR_BITS'(REPEAT_CYCLES - 1);

  state_t               r_state;
  logic [N_WIDTH-1:0]   r_base;
  logic [ADDR_BITS-1:0] r_offset;
  logic [TMR_BITS-1:0]  r_timer;
  logic                 r_rep;
  key_t                 r_key;
  logic [3:0]           r_sync1;
  logic [3:0]           r_sync2;
  logic                 r_go_prev;
  logic                 r_range_go;
  logic [31:0]          r_range_start;
  logic [N_WIDTH-1:0]   r_disp_n;
  logic                 r_browsing;

  logic [3:0]           w_raw_keys;
  logic                 w_go_fall;
  key_t                 w_key;
  logic                 w_press;
  logic                 w_fire;
  logic [TMR_BITS-1:0]  w_nxt_timer;
  logic                 w_nxt_rep;
  state_t               w_nxt_state;
  logic [N_WIDTH-1:0]   w_nxt_base;
  logic [ADDR_BITS-1:0] w_nxt_offset;
  logic                 w_nxt_go;
  logic [31:0]          w_nxt_start;
  logic [N_WIDTH-1:0]   w_nxt_disp;
  logic                 w_nxt_browsing;

  // One offset step in either direction; the bound behaviour is the build-time option.
  function automatic logic [ADDR_BITS-1:0] step_offset(input logic [ADDR_BITS-1:0] off,
                                                       input logic               up);
    logic [ADDR_BITS-1:0] res;
    res = off;
`ifdef RANGE_BROWSER_WRAP_EN
    if (up) begin
      res = (off == OFF_MAX) ? {ADDR_BITS{1'b0}} : off + ADDR_BITS'(1);
    end else begin
      res = (off == {ADDR_BITS{1'b0}}) ? OFF_MAX : off - ADDR_BITS'(1);
    end
`else
    if (up) begin
      res = (off == OFF_MAX) ? off : off + ADDR_BITS'(1);
    end else begin
      res = (off == {ADDR_BITS{1'b0}}) ? off : off - ADDR_BITS'(1);
    end
`endif
    return res;
  endfunction

  // Bit order: [0] go, [1] inc, [2] dec, [3] home; r_sync2 is the synchronised level.
  assign w_raw_keys = {bus.home_key_n, bus.dec_key_n, bus.inc_key_n, bus.go_key_n};
  assign w_go_fall  = r_go_prev & ~r_sync2[0];
  assign w_press    = (w_key != K_NONE) && (w_key != r_key);

  // Resolve the held browse keys into one active key; inc+dec together cancel out.
  always_comb begin
    w_key = K_NONE;
    if (!r_sync2[3]) begin
      w_key = K_HOME;
    end else if (!r_sync2[1] && !r_sync2[2]) begin
      w_key = K_NONE;
    end else if (!r_sync2[1]) begin
      w_key = K_INC;
    end else if (!r_sync2[2]) begin
      w_key = K_DEC;
    end else begin
      w_key = K_NONE;
    end
  end

  // Hold/repeat timer: fires on a fresh press, then after HOLD_CYCLES, then every REPEAT_CYCLES.
  always_comb begin
    w_nxt_timer = r_timer;
    w_nxt_rep   = r_rep;
    w_fire      = 1'b0;
    if ((w_key == K_NONE) || (w_key == K_HOME)) begin
      w_nxt_timer = {TMR_BITS{1'b0}};
      w_nxt_rep   = 1'b0;
    end else if (w_press) begin
      w_fire      = 1'b1;
      w_nxt_timer = {TMR_BITS{1'b0}};
      w_nxt_rep   = 1'b0;
    end else if (r_timer == (r_rep ? REP_LAST : HOLD_LAST)) begin
      w_fire      = 1'b1;
      w_nxt_timer = {TMR_BITS{1'b0}};
      w_nxt_rep   = 1'b1;
    end else begin
      w_nxt_timer = r_timer + TMR_BITS'(1);
    end
  end

  // Next-state and datapath; a go edge relaunches from any state.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_base   = r_base;
    w_nxt_offset = r_offset;
    if (w_go_fall) begin
      w_nxt_state  = S_LAUNCH;
      w_nxt_base   = bus.sw;
      w_nxt_offset = {ADDR_BITS{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          w_nxt_state = S_IDLE;
        end
        S_LAUNCH: begin
          w_nxt_state = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (bus.range_done) begin
            w_nxt_state = S_BROWSE;
          end else begin
            w_nxt_state = S_WAIT_DONE;
          end
        end
        S_BROWSE: begin
          if (w_press && (w_key == K_HOME)) begin
            w_nxt_offset = {ADDR_BITS{1'b0}};
          end else if (w_fire && (w_key == K_INC)) begin
            w_nxt_offset = step_offset(r_offset, 1'b1);
          end else if (w_fire && (w_key == K_DEC)) begin
            w_nxt_offset = step_offset(r_offset, 1'b0);
          end else begin
            w_nxt_offset = r_offset;
          end
        end
        default: begin
          w_nxt_state = S_IDLE;
        end
      endcase
    end
  end

  // Output values are derived from the next state so the registered outputs line up with it.
  always_comb begin
    w_nxt_go       = (w_nxt_state == S_LAUNCH);
    w_nxt_browsing = (w_nxt_state == S_BROWSE);
    if (w_nxt_state == S_BROWSE) begin
      w_nxt_start = 32'(w_nxt_offset);
    end else begin
      w_nxt_start = 32'(w_nxt_base);
    end
    if (w_nxt_state == S_IDLE) begin
      w_nxt_disp = bus.sw;
    end else begin
      w_nxt_disp = w_nxt_base + N_WIDTH'(w_nxt_offset);
    end
  end

  // State, datapath, synchronisers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_base        <= {N_WIDTH{1'b0}};
      r_offset      <= {ADDR_BITS{1'b0}};
      r_timer       <= {TMR_BITS{1'b0}};
      r_rep         <= 1'b0;
      r_key         <= K_NONE;
      r_sync1       <= 4'hF;
      r_sync2       <= 4'hF;
      r_go_prev     <= 1'b1;
      r_range_go    <= 1'b0;
      r_range_start <= 32'h0000_0000;
      r_disp_n      <= {N_WIDTH{1'b0}};
      r_browsing    <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_base        <= w_nxt_base;
      r_offset      <= w_nxt_offset;
      r_timer       <= w_nxt_timer;
      r_rep         <= w_nxt_rep;
      r_key         <= w_key;
      r_sync1       <= w_raw_keys;
      r_sync2       <= r_sync1;
      r_go_prev     <= r_sync2[0];
      r_range_go    <= w_nxt_go;
      r_range_start <= w_nxt_start;
      r_disp_n      <= w_nxt_disp;
      r_browsing    <= w_nxt_browsing;
    end
  end

  assign bus.range_go    = r_range_go;
  assign bus.range_start = r_range_start;
  assign bus.disp_n      = r_disp_n;
  assign bus.browsing    = r_browsing;

endmodule
